sensor_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of `state_machine`. It takes the three raw, asynchronous sensor inputs and produces clean, debounced `sensor1..3` levels that drive `state_machine`'s inputs. Each channel also gets a one-cycle rising-edge pulse. A stuck-high detector forces a channel low and flags a fault if the sensor stays asserted for too long, which silences the downstream buzzer.

---
 rtl/sensor_cond_pkg.sv | 16 +
 rtl/sensor_channel.sv | 152 +++++++++++++++
 rtl/sensor_conditioner.sv | 43 ++++
 tb/tb_sensor_conditioner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sensor_cond_pkg.sv
// Shared types and defaults for the sensor front-end conditioner.
package sensor_cond_pkg;

    localparam int NUM_SENSORS         = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int STUCK_CYCLES_DEF    = 1024;

    typedef enum logic [2:0] {
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND,
        STUCK
    } chan_state_t;

endpackage

// File: rtl/sensor_channel.sv
// One sensor channel: 2-flop synchronizer, debounce and stuck-high detection.
module sensor_channel
    import sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic stuck
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(STUCK_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(STUCK_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic            sync1_q, s_sync_q;
    chan_state_t     state_q, state_d;
    logic [DW-1:0]   db_q, db_d, db_inc;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            stuck_q, stuck_d;

    // Counts are compared post-increment so a level change lands on the
    // edge that completes the run of DEBOUNCE_CYCLES synchronized samples.
    assign db_inc   = (db_q >= DB_MAX) ? db_q : db_q + DB_ONE;
    assign hold_inc = (hold_q >= HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        hold_d  = hold_q;
        unique case (state_q)
            LOW: begin
                db_d = '0;
                if (s_sync_q) begin
                    if (DB_ONE >= DB_MAX) begin
                        state_d = HIGH;
                        hold_d  = '0;
                    end else begin
                        state_d = RISE_PEND;
                        db_d    = DB_ONE;
                    end
                end
            end
            RISE_PEND: begin
                if (!s_sync_q) begin
                    state_d = LOW;
                    db_d    = '0;
                end else if (db_inc >= DB_MAX) begin
                    state_d = HIGH;
                    db_d    = '0;
                    hold_d  = '0;
                end else begin
                    db_d = db_inc;
                end
            end
            HIGH: begin
                if (hold_inc >= HOLD_MAX) begin
                    state_d = STUCK;
                    db_d    = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                    if (!s_sync_q) begin
                        if (DB_ONE >= DB_MAX) begin
                            state_d = LOW;
                            db_d    = '0;
                        end else begin
                            state_d = FALL_PEND;
                            db_d    = DB_ONE;
                        end
                    end
                end
            end
            FALL_PEND: begin
                if (hold_inc >= HOLD_MAX) begin
                    state_d = STUCK;
                    db_d    = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                    if (s_sync_q) begin
                        state_d = HIGH;
                        db_d    = '0;
                    end else if (db_inc >= DB_MAX) begin
                        state_d = LOW;
                        db_d    = '0;
                    end else begin
                        db_d = db_inc;
                    end
                end
            end
            STUCK: begin
                if (s_sync_q) begin
                    db_d = '0;
                end else if (db_inc >= DB_MAX) begin
                    state_d = LOW;
                    db_d    = '0;
                end else begin
                    db_d = db_inc;
                end
            end
            default: begin
                state_d = LOW;
                db_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        level_d = (state_d == HIGH) || (state_d == FALL_PEND);
        rise_d  = (state_d == HIGH) &&
                  ((state_q == RISE_PEND) || (state_q == LOW));
        stuck_d = (state_d == STUCK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            s_sync_q <= 1'b0;
            state_q  <= LOW;
            db_q     <= '0;
            hold_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            sync1_q  <= raw;
            s_sync_q <= sync1_q;
            state_q  <= state_d;
            db_q     <= db_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            stuck_q  <= stuck_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Three independent debounced sensor channels feeding state_machine.
module sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sensor1_raw,
    input  logic                   sensor2_raw,
    input  logic                   sensor3_raw,
    output logic                   sensor1,
    output logic                   sensor2,
    output logic                   sensor3,
    output logic [NUM_SENSORS-1:0] rise_pulse,
    output logic [NUM_SENSORS-1:0] stuck
);

    logic [NUM_SENSORS-1:0] raw_v;
    logic [NUM_SENSORS-1:0] level_v;

    assign raw_v = {sensor3_raw, sensor2_raw, sensor1_raw};

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
        sensor_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_v[i]),
            .level(level_v[i]),
            .rise (rise_pulse[i]),
            .stuck(stuck[i])
        );
    end

    assign sensor1 = level_v[0];
    assign sensor2 = level_v[1];
    assign sensor3 = level_v[2];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=32.
module tb_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       sensor1_raw, sensor2_raw, sensor3_raw;
    logic       sensor1, sensor2, sensor3;
    logic [2:0] rise_pulse;
    logic [2:0] stuck;

    int n_checks;
    int n_fail;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor1_raw(sensor1_raw),
        .sensor2_raw(sensor2_raw),
        .sensor3_raw(sensor3_raw),
        .sensor1    (sensor1),
        .sensor2    (sensor2),
        .sensor3    (sensor3),
        .rise_pulse (rise_pulse),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        int         n;
        logic [2:0] lvl;
        logic [2:0] rise;
        logic [2:0] stk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] raw, input int n,
                       input logic [2:0] lvl, input logic [2:0] rise,
                       input logic [2:0] stk);
        vec_t v;
        v.rst  = r;
        v.raw  = raw;
        v.n    = n;
        v.lvl  = lvl;
        v.rise = rise;
        v.stk  = stk;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, then settle 1 ns before sampling.
    task automatic step(input logic r, input logic [2:0] raw);
        reset       = r;
        sensor1_raw = raw[0];
        sensor2_raw = raw[1];
        sensor3_raw = raw[2];
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [2:0] lvl, input logic [2:0] rise,
                         input logic [2:0] stk);
        logic [8:0] got, exp;
        got = {sensor3, sensor2, sensor1, rise_pulse, stuck};
        exp = {lvl, rise, stk};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got lvl=%b rise=%b stuck=%b, exp lvl=%b rise=%b stuck=%b",
                     name, idx, got[8:6], got[5:3], got[2:0], lvl, rise, stk);
        end
    endtask

    initial begin
        logic [2:0] el, er, es;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        sensor1_raw = 1'b1;
        sensor2_raw = 1'b1;
        sensor3_raw = 1'b1;

        // reset with all raw high, then release
        add(1, 3'b111, 2, 3'b000, 3'b000, 3'b000);
        add(0, 3'b111, 5, 3'b000, 3'b000, 3'b000);
        add(0, 3'b111, 1, 3'b111, 3'b111, 3'b000);
        add(0, 3'b111, 2, 3'b111, 3'b000, 3'b000);
        // debounce on channel 1
        add(1, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        add(0, 3'b001, 5, 3'b000, 3'b000, 3'b000);
        add(0, 3'b001, 1, 3'b001, 3'b001, 3'b000);
        add(0, 3'b001, 3, 3'b001, 3'b000, 3'b000);
        add(0, 3'b000, 5, 3'b001, 3'b000, 3'b000);
        add(0, 3'b000, 4, 3'b000, 3'b000, 3'b000);
        // 3-cycle glitch on channel 2
        add(0, 3'b010, 3, 3'b000, 3'b000, 3'b000);
        add(0, 3'b000, 8, 3'b000, 3'b000, 3'b000);
        // 2-cycle dropout while channel 2 high
        add(0, 3'b010, 5, 3'b000, 3'b000, 3'b000);
        add(0, 3'b010, 1, 3'b010, 3'b010, 3'b000);
        add(0, 3'b010, 2, 3'b010, 3'b000, 3'b000);
        add(0, 3'b000, 2, 3'b010, 3'b000, 3'b000);
        add(0, 3'b010, 8, 3'b010, 3'b000, 3'b000);
        add(0, 3'b000, 5, 3'b010, 3'b000, 3'b000);
        add(0, 3'b000, 3, 3'b000, 3'b000, 3'b000);
        // channels 2 and 3 together
        add(0, 3'b110, 5, 3'b000, 3'b000, 3'b000);
        add(0, 3'b110, 1, 3'b110, 3'b110, 3'b000);
        add(0, 3'b110, 2, 3'b110, 3'b000, 3'b000);
        add(0, 3'b000, 5, 3'b110, 3'b000, 3'b000);
        add(0, 3'b000, 3, 3'b000, 3'b000, 3'b000);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst, vecs[i].raw);
                check("vec", i, vecs[i].lvl, vecs[i].rise, vecs[i].stk);
            end
        end

        // channel 3 held high: 32 cycles high, then stuck
        for (int k = 1; k <= 100; k++) begin
            step(0, 3'b100);
            el = (k >= 6 && k <= 37) ? 3'b100 : 3'b000;
            er = (k == 6) ? 3'b100 : 3'b000;
            es = (k >= 38) ? 3'b100 : 3'b000;
            check("stuck_hold", k, el, er, es);
        end
        // release: stuck clears after 6 edges, no rise pulse
        for (int k = 1; k <= 8; k++) begin
            step(0, 3'b000);
            es = (k < 6) ? 3'b100 : 3'b000;
            check("stuck_release", k, 3'b000, 3'b000, es);
        end

        // reset while stuck, input still high
        for (int k = 1; k <= 40; k++) step(0, 3'b100);
        check("pre_reset_stuck", 0, 3'b000, 3'b000, 3'b100);
        step(1, 3'b100);
        check("reset_in_stuck", 0, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 7; k++) begin
            step(0, 3'b100);
            el = (k >= 6) ? 3'b100 : 3'b000;
            er = (k == 6) ? 3'b100 : 3'b000;
            check("redebounce", k, el, er, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
